// File: rtl/yuv_line_sequencer_pkg.sv
// Shared definitions for the YUV line/frame sequencer.
// State encoding, pad pattern and default counter width.
// Imported by the interface-facing top and the bench.
package yuv_line_sequencer_pkg;

  // Default width of the line-word and line counters
  localparam int CNT_WIDTH_DEFAULT = 16;

  // One 32-bit YUV422 group of black: Y=0x00, U=V=0x80 (LSB first: V, Y1, U, Y0)
  localparam logic [31:0] PAD_WORD32 = 32'h0080_0080;

  // State encoding
  localparam logic [2:0] ST_IDLE_ENC      = 3'd0;
  localparam logic [2:0] ST_SKIP_ENC      = 3'd1;
  localparam logic [2:0] ST_WAIT_LINE_ENC = 3'd2;
  localparam logic [2:0] ST_LINE_ENC      = 3'd3;
  localparam logic [2:0] ST_PAD_ENC       = 3'd4;
  localparam logic [2:0] ST_DROP_ENC      = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = ST_IDLE_ENC,
    ST_SKIP      = ST_SKIP_ENC,
    ST_WAIT_LINE = ST_WAIT_LINE_ENC,
    ST_LINE      = ST_LINE_ENC,
    ST_PAD       = ST_PAD_ENC,
    ST_DROP      = ST_DROP_ENC
  } state_t;

endpackage

// File: rtl/yuv_line_sequencer_if.sv
// Pixel stream bundle between the YUV422 converter, the sequencer and the packer.
// Pure wiring, no latency.
// No ready signal: the stream is never stalled, the sequencer drops excess input.
interface yuv_line_sequencer_if #(
  parameter int PIXEL_PER_CLK = 8
);
  localparam int WORD_W = PIXEL_PER_CLK * 16;

  // Converter side
  logic              frame_start_i;
  logic [WORD_W-1:0] yuv_i;
  logic              yuv_valid_i;
  logic              yuv_line_i;

  // Packer side
  logic [WORD_W-1:0] yuv_o;
  logic              yuv_valid_o;
  logic              line_start_o;
  logic              frame_end_o;

  // Stream source / sink (bench or converter wrapper)
  modport master (
    output frame_start_i, yuv_i, yuv_valid_i, yuv_line_i,
    input  yuv_o, yuv_valid_o, line_start_o, frame_end_o
  );

  // The sequencer itself
  modport slave (
    input  frame_start_i, yuv_i, yuv_valid_i, yuv_line_i,
    output yuv_o, yuv_valid_o, line_start_o, frame_end_o
  );

endinterface

// File: rtl/yuv_line_sequencer.sv
// Windows every line to line_words words (black pad / truncate), counts lines, decimates frames.
// Latency: 1 cycle yuv_i -> yuv_o; all outputs registered.
// No backpressure: input is never stalled; words outside the window are discarded.
module yuv_line_sequencer
  import yuv_line_sequencer_pkg::*;
#(
  parameter int PIXEL_PER_CLK = 8,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  yuv_line_sequencer_if.slave  bus,
  input  logic [CNT_WIDTH-1:0] line_words_i,
  input  logic [CNT_WIDTH-1:0] frame_lines_i,
  input  logic [3:0]           frame_skip_i,
  input  logic                 err_clr_i,
  output logic                 frame_active_o,
  output logic [CNT_WIDTH-1:0] line_count_o,
  output logic                 err_o
);

  localparam int WORD_W = PIXEL_PER_CLK * 16;
  localparam logic [WORD_W-1:0] PAD_WORD = {(PIXEL_PER_CLK / 2){PAD_WORD32}};

  state_t               state;
  logic [CNT_WIDTH-1:0] lw_q;        // line words latched at frame start
  logic [CNT_WIDTH-1:0] fl_q;        // frame lines latched at frame start
  logic [CNT_WIDTH-1:0] word_cnt;    // words emitted in the current line
  logic [3:0]           skip_cnt;    // frames still to drop before the next pass

  logic [CNT_WIDTH-1:0] word_cnt_inc;
  logic [CNT_WIDTH-1:0] line_cnt_inc;
  logic                 last_word;   // the word emitted this cycle closes the line
  logic                 last_line;   // the current line closes the frame
  logic                 cfg_ok;
  logic                 in_frame;
  logic                 fwd_now;     // forward the input word this cycle
  logic                 pad_now;     // emit a black word this cycle
  logic                 err_set;

  assign word_cnt_inc = word_cnt + CNT_WIDTH'(1);
  assign line_cnt_inc = line_count_o + CNT_WIDTH'(1);
  assign last_word    = (word_cnt_inc == lw_q);
  assign last_line    = (line_cnt_inc == fl_q);
  assign cfg_ok       = (line_words_i != '0) && (frame_lines_i != '0);

  assign in_frame = (state == ST_WAIT_LINE) || (state == ST_LINE) ||
                    (state == ST_PAD)       || (state == ST_DROP);

  // A line is opened by the first valid word in WAIT_LINE and continues in LINE.
  assign fwd_now = ((state == ST_WAIT_LINE) || (state == ST_LINE)) && bus.yuv_valid_i;

  // Padding starts in the very cycle the falling line is seen, so pad words
  // follow the last data word without a bubble.
  assign pad_now = (state == ST_PAD) ||
                   ((state == ST_LINE) && !bus.yuv_valid_i && !bus.yuv_line_i);

  // Aborting a passed frame or receiving data while padding is a protocol error.
  assign err_set = (bus.frame_start_i && in_frame) ||
                   ((state == ST_PAD) && bus.yuv_valid_i);

  // Frame/line state machine with registered stream outputs and counters
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state            <= ST_IDLE;
      lw_q             <= '0;
      fl_q             <= '0;
      word_cnt         <= '0;
      skip_cnt         <= '0;
      bus.yuv_o        <= '0;
      bus.yuv_valid_o  <= 1'b0;
      bus.line_start_o <= 1'b0;
      bus.frame_end_o  <= 1'b0;
      frame_active_o   <= 1'b0;
      line_count_o     <= '0;
    end else begin
      bus.yuv_valid_o  <= 1'b0;
      bus.line_start_o <= 1'b0;
      bus.frame_end_o  <= 1'b0;

      if (bus.frame_start_i) begin
        // Frame sync wins over everything; a coincident data word is dropped.
        lw_q     <= line_words_i;
        fl_q     <= frame_lines_i;
        word_cnt <= '0;
        if (!cfg_ok) begin
          state          <= ST_IDLE;
          frame_active_o <= 1'b0;
        end else if (skip_cnt != 4'd0) begin
          skip_cnt       <= skip_cnt - 4'd1;
          state          <= ST_SKIP;
          frame_active_o <= 1'b0;
        end else begin
          skip_cnt       <= frame_skip_i;
          line_count_o   <= '0;
          state          <= ST_WAIT_LINE;
          frame_active_o <= 1'b1;
        end
      end else if (fwd_now || pad_now) begin
        bus.yuv_o        <= fwd_now ? bus.yuv_i : PAD_WORD;
        bus.yuv_valid_o  <= 1'b1;
        bus.line_start_o <= (state == ST_WAIT_LINE);
        bus.frame_end_o  <= last_word && last_line;
        word_cnt         <= word_cnt_inc;
        if (last_word) begin
          if (fwd_now && bus.yuv_line_i) begin
            // Line is longer than the window: swallow the rest of it.
            state <= ST_DROP;
          end else begin
            line_count_o <= line_cnt_inc;
            word_cnt     <= '0;
            state        <= last_line ? ST_IDLE : ST_WAIT_LINE;
          end
        end else if (fwd_now && bus.yuv_line_i) begin
          state <= ST_LINE;
        end else begin
          state <= ST_PAD;
        end
      end else if ((state == ST_DROP) && !bus.yuv_line_i) begin
        line_count_o <= line_cnt_inc;
        word_cnt     <= '0;
        state        <= last_line ? ST_IDLE : ST_WAIT_LINE;
      end else if (state == ST_IDLE) begin
        // Held one cycle past frame_end_o so the last word is still inside the frame.
        frame_active_o <= 1'b0;
      end
    end
  end

  // Sticky error flag; a new error in the clearing cycle keeps it set
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_o <= 1'b0;
    end else begin
      err_o <= err_set | (err_o & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_yuv_line_sequencer.sv
// Bench for yuv_line_sequencer: directed scenarios plus random frames,
// output stream compared word by word (data, markers, cycle of arrival).
module tb_yuv_line_sequencer;

  localparam int PPC = 8;
  localparam int W   = PPC * 16;
  localparam int CW  = 16;
  localparam logic [W-1:0] PAD = {(PPC / 2){32'h0080_0080}};

  typedef struct packed {
    logic [W-1:0] dat;
    logic         ls;
    logic         fe;
    logic [31:0]  cyc;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CW-1:0] line_words  = '0;
  logic [CW-1:0] frame_lines = '0;
  logic [3:0]    frame_skip  = '0;
  logic          err_clr     = 1'b0;
  logic          frame_active;
  logic [CW-1:0] line_count;
  logic          err;
  logic [31:0]   cyc = '0;

  int    errors = 0;
  int    checks = 0;
  int    skip_left = 0;    // frames the bench expects to be dropped next
  int    lens[8];
  word_t got_q[$];
  word_t exp_q[$];

  yuv_line_sequencer_if #(.PIXEL_PER_CLK(PPC)) bus ();

  yuv_line_sequencer #(.PIXEL_PER_CLK(PPC), .CNT_WIDTH(CW)) dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .bus            (bus),
    .line_words_i   (line_words),
    .frame_lines_i  (frame_lines),
    .frame_skip_i   (frame_skip),
    .err_clr_i      (err_clr),
    .frame_active_o (frame_active),
    .line_count_o   (line_count),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  // Collect every output word with the cycle it appeared in
  always @(negedge clk) begin
    if (!rst && bus.yuv_valid_o === 1'b1)
      got_q.push_back(word_t'{bus.yuv_o, bus.line_start_o, bus.frame_end_o, cyc});
  end

  // One input line of n words, then a low gap long enough for padding/drop to finish.
  // The word the line must produce at window position k leaves 1 cycle after input slot k.
  task automatic drive_line(input int lw, input int n, input bit passed, input bit last, input int inj);
    int c0;
    logic [W-1:0] d;
    c0 = cyc;
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < W / 32; b++) d[b*32 +: 32] = $urandom();
      bus.yuv_i = d; bus.yuv_valid_i = 1'b1; bus.yuv_line_i = 1'b1;
      if (passed && k < lw)
        exp_q.push_back(word_t'{d, 1'(k == 0), 1'(last && k == lw - 1), 32'(c0 + k + 1)});
      @(negedge clk);
    end
    bus.yuv_valid_i = 1'b0; bus.yuv_line_i = 1'b0;
    if (passed)
      for (int k = n; k < lw; k++)
        exp_q.push_back(word_t'{PAD, 1'(k == 0), 1'(last && k == lw - 1), 32'(c0 + k + 1)});
    for (int g = 0; g < lw + 2; g++) begin
      bus.yuv_valid_i = (g == inj);
      @(negedge clk);
    end
    bus.yuv_valid_i = 1'b0;
  endtask

  // Frame sync plus lens[0..fl-1] lines; pass/skip decided from the frame-start rule
  task automatic drive_frame(input int lw, input int fl, input int sk, output bit passed, output logic fa);
    @(negedge clk);
    bus.frame_start_i = 1'b1;
    line_words = CW'(lw); frame_lines = CW'(fl); frame_skip = 4'(sk);
    if (lw == 0 || fl == 0) passed = 1'b0;
    else if (skip_left != 0) begin skip_left--; passed = 1'b0; end
    else begin skip_left = sk; passed = 1'b1; end
    @(negedge clk);
    bus.frame_start_i = 1'b0;
    fa = frame_active;
    for (int j = 0; j < fl; j++) drive_line(lw, lens[j], passed, j == fl - 1, -1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.frame_start_i = 1'b0; bus.yuv_i = '0; bus.yuv_valid_i = 1'b0; bus.yuv_line_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.yuv_o !== '0)          begin errors++; $display("FAIL reset_yuv_o: got %h required 0", bus.yuv_o); end
    checks++; if (bus.yuv_valid_o !== 1'b0)  begin errors++; $display("FAIL reset_valid: got %b required 0", bus.yuv_valid_o); end
    checks++; if (bus.line_start_o !== 1'b0) begin errors++; $display("FAIL reset_line_start: got %b required 0", bus.line_start_o); end
    checks++; if (bus.frame_end_o !== 1'b0)  begin errors++; $display("FAIL reset_frame_end: got %b required 0", bus.frame_end_o); end
    checks++; if (frame_active !== 1'b0)     begin errors++; $display("FAIL reset_frame_active: got %b required 0", frame_active); end
    checks++; if (line_count !== '0)         begin errors++; $display("FAIL reset_line_count: got %0d required 0", line_count); end
    checks++; if (err !== 1'b0)              begin errors++; $display("FAIL reset_err: got %b required 0", err); end
    rst = 1'b0;
    skip_left = 0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    bit passed; logic fa;
    got_q.delete(); exp_q.delete();
    lens[0] = 4; lens[1] = 4;
    drive_frame(4, 2, 0, passed, fa);
    checks++; if (exp_q.size() != 8) begin errors++; $display("FAIL basic_expected_len: got %0d required 8", exp_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
    checks++; if (fa !== 1'b1) begin errors++; $display("FAIL basic_frame_active: got %b required 1", fa); end
    checks++; if (line_count !== 16'd2) begin errors++; $display("FAIL basic_line_count: got %0d required 2", line_count); end
    checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL basic_frame_done: got %b required 0", frame_active); end
  endtask

  task automatic test_pad();
    bit passed; logic fa;
    got_q.delete(); exp_q.delete();
    lens[0] = 3;
    drive_frame(6, 1, 0, passed, fa);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL pad_count: got %0d required 6", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pad_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pad_err: got %b required 0", err); end
  endtask

  task automatic test_drop();
    bit passed; logic fa;
    got_q.delete(); exp_q.delete();
    lens[0] = 7;
    drive_frame(4, 1, 0, passed, fa);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL drop_count: got %0d required 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL drop_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL drop_err: got %b required 0", err); end
    checks++; if (line_count !== 16'd1) begin errors++; $display("FAIL drop_line_count: got %0d required 1", line_count); end
  endtask

  task automatic test_pad_err();
    got_q.delete(); exp_q.delete();
    @(negedge clk);
    bus.frame_start_i = 1'b1; line_words = 16'd8; frame_lines = 16'd1; frame_skip = 4'd0;
    skip_left = 0;
    @(negedge clk);
    bus.frame_start_i = 1'b0;
    drive_line(8, 2, 1'b1, 1'b1, 1);
    checks++; if (got_q.size() != 8) begin errors++; $display("FAIL pad_err_count: got %0d required 8", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL pad_err_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL pad_err_set: got %b required 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL pad_err_clear: got %b required 0", err); end
  endtask

  task automatic test_skip();
    bit passed; logic fa;
    bit pass_pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    got_q.delete(); exp_q.delete();
    lens[0] = 3; lens[1] = 2;
    for (int f = 0; f < 6; f++) begin
      drive_frame(3, 2, 2, passed, fa);
      checks++;
      if (fa !== pass_pat[f]) begin errors++; $display("FAIL skip_frame_active%0d: got %b required %b", f, fa, pass_pat[f]); end
    end
    checks++; if (exp_q.size() != 12) begin errors++; $display("FAIL skip_expected_len: got %0d required 12", exp_q.size()); end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL skip_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL skip_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_abort();
    int c0;
    logic [W-1:0] d;
    got_q.delete(); exp_q.delete();
    @(negedge clk);
    bus.frame_start_i = 1'b1; line_words = 16'd4; frame_lines = 16'd3; frame_skip = 4'd0;
    skip_left = 0;
    @(negedge clk);
    bus.frame_start_i = 1'b0;
    drive_line(4, 4, 1'b1, 1'b0, -1);
    // second line cut short by a new frame sync
    c0 = cyc;
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < W / 32; b++) d[b*32 +: 32] = $urandom();
      bus.yuv_i = d; bus.yuv_valid_i = 1'b1; bus.yuv_line_i = 1'b1;
      exp_q.push_back(word_t'{d, 1'(k == 0), 1'b0, 32'(c0 + k + 1)});
      @(negedge clk);
    end
    bus.yuv_i = ~d; bus.frame_start_i = 1'b1; err_clr = 1'b1;
    @(negedge clk);
    bus.frame_start_i = 1'b0; err_clr = 1'b0; bus.yuv_valid_i = 1'b0; bus.yuv_line_i = 1'b0;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err_set: got %b required 1", err); end
    checks++; if (line_count !== 16'd0) begin errors++; $display("FAIL abort_line_count: got %0d required 0", line_count); end
    for (int j = 0; j < 3; j++) drive_line(4, 3 + j, 1'b1, j == 2, -1);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL abort_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL abort_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
    checks++; if (line_count !== 16'd3) begin errors++; $display("FAIL abort_new_frame_lines: got %0d required 3", line_count); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err_sticky: got %b required 1", err); end
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clear: got %b required 0", err); end
  endtask

  task automatic test_back_to_back();
    bit passed; logic fa;
    int lw, fl, sk;
    got_q.delete(); exp_q.delete();
    // one-word lines on a one-line frame: start and end markers on the same word
    lens[0] = 3;
    drive_frame(1, 1, 0, passed, fa);
    for (int f = 0; f < 10; f++) begin
      lw = $urandom_range(0, 5);
      fl = $urandom_range(1, 3);
      sk = $urandom_range(0, 1);
      for (int j = 0; j < fl; j++) lens[j] = $urandom_range(1, 7);
      drive_frame(lw, fl, sk, passed, fa);
      checks++;
      if (fa !== passed) begin errors++; $display("FAIL b2b_frame_active%0d: got %b required %b", f, fa, passed); end
    end
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
  endtask

  task automatic test_reset_mid_pad();
    bit passed; logic fa;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    skip_left = 0;
    @(negedge clk);
    bus.frame_start_i = 1'b1; line_words = 16'd8; frame_lines = 16'd2; frame_skip = 4'd0;
    @(negedge clk);
    bus.frame_start_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.yuv_i = {W/32{$urandom()}}; bus.yuv_valid_i = 1'b1; bus.yuv_line_i = 1'b1;
      @(negedge clk);
    end
    bus.yuv_valid_i = 1'b0; bus.yuv_line_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.yuv_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pad_active: got %b required 1", bus.yuv_valid_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.yuv_valid_o !== 1'b0) begin errors++; $display("FAIL rst_pad_valid: got %b required 0", bus.yuv_valid_o); end
    checks++; if (bus.yuv_o !== '0)         begin errors++; $display("FAIL rst_pad_yuv_o: got %h required 0", bus.yuv_o); end
    checks++; if (frame_active !== 1'b0)    begin errors++; $display("FAIL rst_pad_frame_active: got %b required 0", frame_active); end
    checks++; if (line_count !== '0)        begin errors++; $display("FAIL rst_pad_line_count: got %0d required 0", line_count); end
    @(negedge clk);
    rst = 1'b0;
    skip_left = 0;
    got_q.delete(); exp_q.delete();
    lens[0] = 4;
    drive_frame(4, 1, 0, passed, fa);
    checks++; if (fa !== 1'b1) begin errors++; $display("FAIL rst_pad_next_frame: got %b required 1", fa); end
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL rst_pad_count: got %0d required 4", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rst_pad_word%0d: got %h ls=%b fe=%b cyc=%0d required %h ls=%b fe=%b cyc=%0d", i,
                 got_q[i].dat, got_q[i].ls, got_q[i].fe, got_q[i].cyc, exp_q[i].dat, exp_q[i].ls, exp_q[i].fe, exp_q[i].cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pad();
    test_drop();
    test_pad_err();
    test_skip();
    test_abort();
    test_back_to_back();
    test_reset_mid_pad();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/yuv_line_sequencer.md
# yuv_line_sequencer

Frame and line sequencer placed between the RGB→YUV422 converter output and the GPIF/USB packer. It windows each line to exactly `line_words_i` output words, padding short lines with black and truncating long ones. It counts lines to `frame_lines_i` and decimates frames by `frame_skip_i`. It also emits line and frame markers, so the host always receives rectangular frames of fixed size.

## Interface
Parameters:
- `PIXEL_PER_CLK`, 8: pixels per input word; word is `PIXEL_PER_CLK*16` bits of packed YUV422.
- `CNT_WIDTH`, 16: width of the line-word and line counters and their config inputs.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `frame_start_i`  in  1  one-cycle frame sync pulse.
- `yuv_i`  in  `PIXEL_PER_CLK*16`  packed YUV422 word. Byte order per 32-bit group, LSB first: V, Y1, U, Y0.
- `yuv_valid_i`  in  1  `yuv_i` valid this cycle.
- `yuv_line_i`  in  1  line active from the converter.
- `line_words_i`  in  `CNT_WIDTH`  output words per line; sampled at frame start.
- `frame_lines_i`  in  `CNT_WIDTH`  lines per frame; sampled at frame start.
- `frame_skip_i`  in  4  frames dropped after each passed frame; sampled at frame start.
- `err_clr_i`  in  1  clears `err_o`.
- `yuv_o`  out  `PIXEL_PER_CLK*16`  output word.
- `yuv_valid_o`  out  1  output word valid.
- `line_start_o`  out  1  high with the first word of each line.
- `frame_end_o`  out  1  high with the last word of each frame.
- `frame_active_o`  out  1  high while a passed frame is in progress.
- `line_count_o`  out  `CNT_WIDTH`  lines completed in the current frame.
- `err_o`  out  1  sticky protocol error.

## Operation
- States are IDLE, SKIP, WAIT_LINE, LINE, PAD, DROP.
- **IDLE**: on `frame_start_i`, sample the three config inputs and then:
  - if either sampled size is 0, stay in IDLE;
  - else if the skip counter ≠ 0, decrement it and go to SKIP;
  - else reload the skip counter from `frame_skip_i`, clear `line_count_o`, and go to WAIT_LINE.
- **SKIP**: discard all input; `frame_start_i` is handled exactly as in IDLE.
- **WAIT_LINE**: clear the word counter. The first `yuv_valid_i` is forwarded with `line_start_o`, and the state moves to LINE.
- **LINE**: forward each valid word and increment the word counter.
  - When the counter reaches `line_words_i`, the line is complete. If `yuv_line_i` is still high, go to DROP; otherwise go to end-of-line.
  - If `yuv_line_i` falls while the counter is below `line_words_i`, go to PAD.
- **PAD**: emit one pad word per cycle until the counter reaches `line_words_i`.
  - The pad word is `{PIXEL_PER_CLK/2{32'h0080_0080}}`, i.e. Y=0x00, U=V=0x80.
  - Any `yuv_valid_i` during PAD is discarded and sets `err_o`.
- **DROP**: discard input until `yuv_line_i` is low, then go to end-of-line.
- **End-of-line**: increment `line_count_o`.
  - If it equals `frame_lines_i`, the last word of the line carries `frame_end_o` and the state returns to IDLE.
  - Otherwise go to WAIT_LINE.
- **Frame start mid-frame**: `frame_start_i` in WAIT_LINE, LINE, PAD or DROP aborts the frame. `err_o` is set, no `frame_end_o` is emitted, and the IDLE frame-start handling is applied in the same cycle.
- `err_o` stays set until `err_clr_i` or reset. If set and clear occur in the same cycle, set wins.
- Counter arithmetic is unsigned `CNT_WIDTH`; counters cannot wrap because they are bounded by the sampled config.

## Timing
- All outputs are registered. Data latency is 1 cycle from `yuv_i` to `yuv_o`.
- `line_start_o` and `frame_end_o` are one-cycle pulses aligned with the corresponding `yuv_valid_o` word.
  - If `line_words_i` = 1 and this is the last line, both pulses occur in the same cycle.
- A `frame_start_i` at cycle t puts the block in WAIT_LINE at t+1. A valid word coincident with `frame_start_i` is dropped.
- PAD words are emitted back-to-back, starting the cycle after the falling `yuv_line_i` is sampled.
- `yuv_o` holds its last value when `yuv_valid_o` is 0.
- Reset values:
  - all outputs 0, except `yuv_o`, which also resets to 0;
  - state IDLE, all counters 0, skip counter 0, so the first frame after reset is passed.
- Reset mid-line gives immediate return to IDLE with no trailing words.

## Structure
- Shared package/header holds:
  - the state encoding localparams;
  - the 32-bit pad constant `32'h0080_0080`;
  - the default `CNT_WIDTH`.
- Single module. The state machine, counters and skip logic are tightly coupled, so no sub-module is warranted.

## Test plan
- `line_words`=4, `frame_lines`=2, two lines of 4 valid words each → 8 output words, 1-cycle latency, `line_start_o` on words 1 and 5, `frame_end_o` on word 8, `line_count_o`=2.
- `line_words`=6, input line of 3 words then `yuv_line_i` low → 3 data words plus 3 pad words of `0x0080_0080` pattern, contiguous output.
- `line_words`=4, input line of 7 words → 4 forwarded words; words 5–7 dropped; `err_o` stays 0.
- `frame_skip`=2, 6 frames → only frames 1 and 4 produce output; `frame_active_o` low during the skipped frames.
- `frame_start_i` during line 1 of 3 → `err_o` set, new frame starts with `line_count_o`=0; `err_clr_i` clears `err_o`.
- `reset_i` asserted mid-PAD → all outputs 0 immediately; after release the next `frame_start_i` passes the frame.
